// File: rtl/sbox5_pkg.sv
// sbox5_pkg
// Shared definitions for the DES S-box 5 inverse-lookup engine:
//   - engine state enumeration (IDLE / SEARCH / EMIT)
//   - S-box input/output widths and the number of preimages per output value
package sbox5_pkg;

    localparam int SBOX_IN_W         = 6;
    localparam int SBOX_OUT_W        = 4;
    localparam int MATCHES_PER_VALUE = 4;
    localparam int MATCH_CNT_W       = $clog2(MATCHES_PER_VALUE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        EMIT   = 2'd2
    } state_e;

endpackage

// File: rtl/sbox5.sv
// sbox5
// Combinational forward DES S-box 5.
// Ports:
//   sbox_in  [5:0] : S-box input; row = {bit5, bit0}, column = bits[4:1]
//   sbox_out [3:0] : S-box output
module sbox5
    import sbox5_pkg::*;
(
    input  logic [SBOX_IN_W-1:0]  sbox_in,
    output logic [SBOX_OUT_W-1:0] sbox_out
);

    // Each row packed as 16 nibbles, column 0 in the least significant nibble.
    localparam logic [3:0][63:0] SBOX5_ROWS = {
        64'h354A_90F6_D2E1_7C8B,   // row 3
        64'hE036_5C9F_87DA_B124,   // row 2
        64'h6893_AF05_1D74_C2BE,   // row 1
        64'h9E0D_F358_6BA7_14C2    // row 0
    };

    logic [1:0]            row;
    logic [3:0]            col;
    logic [SBOX_OUT_W-1:0] row_out [4];

    assign row = {sbox_in[5], sbox_in[0]};
    assign col = sbox_in[4:1];

    // Look up the column in every row in parallel, then pick the row.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign row_out[gi] = SBOX5_ROWS[gi][{col, 2'b00} +: 4];
        end
    endgenerate

    assign sbox_out = row_out[row];

endmodule

// File: rtl/sbox5_preimage.sv
// sbox5_preimage
// Sequential inverse lookup for DES S-box 5. A request carries a 4-bit output
// value; the engine walks all 6-bit inputs in ascending order through the
// forward S-box and streams each input that maps to the value. Every value has
// exactly four preimages, and the scan stops as soon as the fourth is emitted.
// Ports:
//   wb_clk_i / wb_rst_i      : clock, asynchronous active-high reset
//   req_valid/req_ready      : request handshake, req_ready high only when idle
//   req_value [3:0]          : value to invert, sampled on accept
//   out_valid/out_ready      : preimage stream handshake
//   out_data  [5:0]          : preimage (S-box input encoding)
//   out_last                 : marks the final preimage of the request
module sbox5_preimage
    import sbox5_pkg::*;
(
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SBOX_OUT_W-1:0] req_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SBOX_IN_W-1:0]  out_data,
    output logic                  out_last
);

    localparam logic [SBOX_IN_W-1:0]   INDEX_MAX  = '1;
    localparam logic [MATCH_CNT_W-1:0] LAST_MATCH = MATCH_CNT_W'(MATCHES_PER_VALUE - 1);

    state_e                  state_q,     state_d;
    logic [SBOX_IN_W-1:0]    index_q,     index_d;
    logic [MATCH_CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic [SBOX_OUT_W-1:0]   value_q,     value_d;
    logic [SBOX_IN_W-1:0]    out_data_q,  out_data_d;
    logic                    out_last_q,  out_last_d;

    logic [SBOX_OUT_W-1:0]   sbox_out;

    sbox5 u_sbox5 (
        .sbox_in  (index_q),
        .sbox_out (sbox_out)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            index_q     <= '0;
            match_cnt_q <= '0;
            value_q     <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            match_cnt_q <= match_cnt_d;
            value_q     <= value_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        match_cnt_d = match_cnt_q;
        value_d     = value_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    value_d     = req_value;
                    index_d     = '0;
                    match_cnt_d = '0;
                    state_d     = SEARCH;
                end
            end
            SEARCH: begin
                if (sbox_out == value_q) begin
                    out_data_d = index_q;
                    // Index 63 as a last-marker only matters with a faulty table;
                    // it keeps the index from wrapping inside one request.
                    out_last_d = (match_cnt_q == LAST_MATCH) || (index_q == INDEX_MAX);
                    index_d    = index_q + 1'b1;
                    state_d    = EMIT;
                end else if (index_q == INDEX_MAX) begin
                    state_d = IDLE;
                end else begin
                    index_d = index_q + 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    match_cnt_d = match_cnt_q + 1'b1;
                    state_d     = out_last_q ? IDLE : SEARCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready is masked by reset so it reads low while reset is held.
    assign req_ready = (state_q == IDLE) && !wb_rst_i;
    assign out_valid = (state_q == EMIT);
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule
